// File: rtl/dlfloat_pkg.sv
// Shared types and DLFloat16 constants for the dlfloat MAC scheduler.
// DLFloat16 layout: 1 sign bit, 6 exponent bits (bias 31), 9 mantissa bits.
package dlfloat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FEED   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4
    } sched_state_t;

    localparam logic [15:0] DLF_ZERO = 16'h0000;
    localparam logic [15:0] DLF_ONE  = 16'h3E00;
    localparam logic [15:0] DLF_TWO  = 16'h4000;
    localparam logic [15:0] DLF_NAN  = 16'hFFFF;

endpackage

// File: rtl/dlfloat_mac_scheduler_rr_arb2.sv
// Two-way round-robin pick.
// The requester named by rr_ptr_i wins whenever it is valid; otherwise the other one does.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       rr_ptr_i,
    output logic [1:0] grant_o,
    output logic       gnt_idx_o
);

    always_comb begin
        grant_o   = 2'b00;
        gnt_idx_o = rr_ptr_i;
        if (valid_i[rr_ptr_i]) begin
            gnt_idx_o = rr_ptr_i;
            grant_o   = rr_ptr_i ? 2'b10 : 2'b01;
        end else if (valid_i[~rr_ptr_i]) begin
            gnt_idx_o = ~rr_ptr_i;
            grant_o   = rr_ptr_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dlfloat_mac_scheduler.sv
// Shares one dlfloat MAC between two requesters, one dot-product job at a time.
// Each job runs: clear the accumulator, feed operand pairs, drain the MAC pipeline, present the result.
module dlfloat_mac_scheduler
    import dlfloat_pkg::*;
#(
    parameter int MAC_LAT = 2,
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic [1:0]  req_last_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic        res_id_o,
    output logic [15:0] res_data_o,
    output logic        res_ovf_o,
    output logic        mac_clr_o,
    output logic        mac_en_o,
    output logic [15:0] mac_a_o,
    output logic [15:0] mac_b_o,
    input  logic [15:0] mac_acc_i
);

    localparam int DRAIN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    sched_state_t       state_q, state_d;
    logic               gnt_q, gnt_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        res_data_q, res_data_d;
    logic               res_id_q, res_id_d;
    logic               res_ovf_q, res_ovf_d;

    logic [1:0]         arb_grant;
    logic               arb_idx;
    logic [15:0]        sel_a, sel_b;
    logic               sel_last;

    rr_arb2 u_arb (
        .valid_i   (req_valid_i),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (arb_grant),
        .gnt_idx_o (arb_idx)
    );

    assign sel_a    = gnt_q ? req_a_i[31:16] : req_a_i[15:0];
    assign sel_b    = gnt_q ? req_b_i[31:16] : req_b_i[15:0];
    assign sel_last = req_last_i[gnt_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            rr_ptr_q    <= 1'b0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            ovf_q       <= 1'b0;
            res_data_q  <= DLF_ZERO;
            res_id_q    <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            ovf_q       <= ovf_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        ovf_d       = ovf_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_ovf_d   = res_ovf_q;
        req_ready_o = 2'b00;
        res_valid_o = 1'b0;
        mac_clr_o   = 1'b0;
        mac_en_o    = 1'b0;
        mac_a_o     = DLF_ZERO;
        mac_b_o     = DLF_ZERO;

        case (state_q)
            ST_IDLE: begin
                if (|arb_grant) begin
                    gnt_d   = arb_idx;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                mac_clr_o  = 1'b1;
                beat_cnt_d = '0;
                ovf_d      = 1'b0;
                state_d    = ST_FEED;
            end
            ST_FEED: begin
                // Operands reach the MAC in the same cycle as the handshake; bubbles simply idle the MAC.
                req_ready_o = gnt_q ? 2'b10 : 2'b01;
                if (req_valid_i[gnt_q]) begin
                    mac_en_o   = 1'b1;
                    mac_a_o    = sel_a;
                    mac_b_o    = sel_b;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (sel_last || (beat_cnt_q == CNT_W'(MAX_LEN - 1))) begin
                        ovf_d       = ~sel_last;
                        drain_cnt_d = DRAIN_W'(MAC_LAT);
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    res_data_d = mac_acc_i;
                    res_id_d   = gnt_q;
                    res_ovf_d  = ovf_q;
                    state_d    = ST_RESULT;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end
            ST_RESULT: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    rr_ptr_d = ~gnt_q;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign res_data_o = res_data_q;
    assign res_id_o   = res_id_q;
    assign res_ovf_o  = res_ovf_q;

endmodule

// File: tb/tb_dlfloat_mac_scheduler.sv
// Testbench for dlfloat_mac_scheduler: a behavioural DLFloat16 MAC, per-requester beat drivers,
// a job-level reference model and scoreboard, directed vector table, and randomized traffic.
module tb_dlfloat_mac_scheduler;
    import dlfloat_pkg::*;

    localparam int MacLat = 2;
    localparam int MaxLen = 4;
    localparam int CntW   = 3;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          last;
        int          bubble;
    } beat_t;

    typedef struct {
        bit          id;
        logic [15:0] data;
        bit          ovf;
    } res_t;

    typedef struct {
        int          id;
        logic [15:0] a0, b0, a1, b1;
        int          nBeats;
        int          bubble;
        logic [15:0] expData;
        bit          expOvf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  reqValid = 2'b00;
    logic [1:0]  reqReady;
    logic [31:0] reqA = '0;
    logic [31:0] reqB = '0;
    logic [1:0]  reqLast = 2'b00;
    logic        resValid;
    logic        resReady = 1'b1;
    logic        resId;
    logic [15:0] resData;
    logic        resOvf;
    logic        macClr, macEn;
    logic [15:0] macA, macB, macAcc;

    int checks = 0;
    int errors = 0;
    int clrCount = 0;
    int enCount = 0;
    int readyMode = 1;
    bit holdDrive = 1'b0;

    beat_t beatQ[2][$];
    int    bubbleUsed[2];
    res_t  expQ[2][$];
    res_t  resLog[$];
    real   partSum[2];
    bit    partNan[2];
    int    partCnt[2];

    always #5 clk = ~clk;

    dlfloat_mac_scheduler #(.MAC_LAT(MacLat), .MAX_LEN(MaxLen), .CNT_W(CntW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(reqValid), .req_ready_o(reqReady),
        .req_a_i(reqA), .req_b_i(reqB), .req_last_i(reqLast),
        .res_valid_o(resValid), .res_ready_i(resReady),
        .res_id_o(resId), .res_data_o(resData), .res_ovf_o(resOvf),
        .mac_clr_o(macClr), .mac_en_o(macEn),
        .mac_a_o(macA), .mac_b_o(macB), .mac_acc_i(macAcc)
    );

    function automatic real dlfToReal(input logic [15:0] v);
        int  e;
        real r;
        if (v[14:0] == 15'd0) return 0.0;
        e = int'(v[14:9]);
        r = 1.0 + real'(v[8:0]) / 512.0;
        for (int i = 31; i < e; i++) r = r * 2.0;
        for (int i = e; i < 31; i++) r = r / 2.0;
        return v[15] ? -r : r;
    endfunction

    function automatic logic [15:0] realToDlf(input real x);
        logic s;
        real  m;
        int   e;
        int   mant;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        m = s ? -x : x;
        e = 31;
        while (m >= 2.0 && e < 63) begin m = m / 2.0; e++; end
        while (m < 1.0 && e > 1) begin m = m * 2.0; e--; end
        mant = $rtoi((m - 1.0) * 512.0);
        return {s, e[5:0], mant[8:0]};
    endfunction

    // Behavioural MAC: one register stage for the product, one for the accumulator.
    real  prodR, accR;
    logic prodV, prodNan, accNan;
    always @(posedge clk) begin
        if (rst) begin
            prodV <= 1'b0; prodR <= 0.0; prodNan <= 1'b0; accR <= 0.0; accNan <= 1'b0;
        end else begin
            prodV   <= macEn;
            prodR   <= dlfToReal(macA) * dlfToReal(macB);
            prodNan <= (macA == DLF_NAN) || (macB == DLF_NAN);
            if (macClr) begin
                accR <= 0.0; accNan <= 1'b0;
            end else if (prodV) begin
                accR <= accR + prodR; accNan <= accNan | prodNan;
            end
        end
    end
    always_comb macAcc = accNan ? DLF_NAN : realToDlf(accR);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [15:0] a, input logic [15:0] b,
                                 input bit last, input int bubble);
        beat_t bt;
        bt.a = a; bt.b = b; bt.last = last; bt.bubble = bubble;
        beatQ[r].push_back(bt);
    endtask

    // Reference model: a job ends on last or at MaxLen accepted beats; its result is the exact dot product.
    task automatic modelAccept(input int r, input beat_t bt);
        res_t e;
        partSum[r] = partSum[r] + dlfToReal(bt.a) * dlfToReal(bt.b);
        partNan[r] = partNan[r] | (bt.a == DLF_NAN) | (bt.b == DLF_NAN);
        partCnt[r]++;
        if (bt.last || partCnt[r] == MaxLen) begin
            e.id   = r[0];
            e.data = partNan[r] ? DLF_NAN : realToDlf(partSum[r]);
            e.ovf  = !bt.last;
            expQ[r].push_back(e);
            partSum[r] = 0.0; partNan[r] = 1'b0; partCnt[r] = 0;
        end
    endtask

    task automatic clearModel();
        for (int r = 0; r < 2; r++) begin
            beatQ[r].delete(); expQ[r].delete();
            bubbleUsed[r] = 0; partSum[r] = 0.0; partNan[r] = 1'b0; partCnt[r] = 0;
        end
    endtask

    // Requester drivers: present the queue head (after its bubble cycles) and hold it until accepted.
    always begin
        @(posedge clk); #1;
        for (int r = 0; r < 2; r++) begin
            reqValid[r] = 1'b0;
            reqLast[r]  = 1'b0;
            if (!holdDrive && beatQ[r].size() > 0) begin
                if (bubbleUsed[r] < beatQ[r][0].bubble) begin
                    bubbleUsed[r]++;
                end else begin
                    reqValid[r]         = 1'b1;
                    reqA[r*16 +: 16]    = beatQ[r][0].a;
                    reqB[r*16 +: 16]    = beatQ[r][0].b;
                    reqLast[r]          = beatQ[r][0].last;
                end
            end
        end
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            if (!rst && reqValid[r] && reqReady[r] && beatQ[r].size() > 0) begin
                modelAccept(r, beatQ[r].pop_front());
                bubbleUsed[r] = 0;
            end
        end
    end

    always begin
        @(posedge clk); #1;
        case (readyMode)
            0:       resReady = 1'b0;
            1:       resReady = 1'b1;
            default: resReady = 1'($urandom_range(0, 1));
        endcase
    end

    // Per-cycle protocol checks and the result scoreboard.
    always @(negedge clk) begin
        res_t got, e;
        if (macClr) clrCount++;
        if (macEn)  enCount++;
        if (!rst) begin
            checkOutput("readyAtMostOne", 32'($countones(reqReady) <= 1), 32'd1);
            checkOutput("macEnIsHandshake", 32'(macEn), 32'(|(reqValid & reqReady)));
            if (macEn) begin
                checkOutput("macA", 32'(macA), 32'(reqReady[1] ? reqA[31:16] : reqA[15:0]));
                checkOutput("macB", 32'(macB), 32'(reqReady[1] ? reqB[31:16] : reqB[15:0]));
            end
            if (resValid && resReady) begin
                got.id = resId; got.data = resData; got.ovf = resOvf;
                resLog.push_back(got);
                if (expQ[resId].size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpectedResult: got id %0d data %h, expected no result", resId, resData);
                end else begin
                    e = expQ[resId].pop_front();
                    checkOutput("scoreData", 32'(resData), 32'(e.data));
                    checkOutput("scoreOvf", 32'(resOvf), 32'(e.ovf));
                end
            end
        end
    end

    task automatic waitResult(input int maxCyc, output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        for (int k = 0; k < maxCyc; k++) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (resValid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic waitLogCount(input int target, input int maxCyc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < maxCyc; k++) begin
            @(negedge clk); #1;
            if (resLog.size() >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic waitAllDone(input int maxCyc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < maxCyc; k++) begin
            @(negedge clk); #1;
            if (beatQ[0].size() == 0 && beatQ[1].size() == 0 &&
                expQ[0].size() == 0 && expQ[1].size() == 0 && !resValid) begin
                ok = 1'b1; break;
            end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_reqReady"}, 32'(reqReady), 32'd0);
        checkOutput({tag, "_resValid"}, 32'(resValid), 32'd0);
        checkOutput({tag, "_resId"},    32'(resId),    32'd0);
        checkOutput({tag, "_resData"},  32'(resData),  32'd0);
        checkOutput({tag, "_resOvf"},   32'(resOvf),   32'd0);
        checkOutput({tag, "_macClr"},   32'(macClr),   32'd0);
        checkOutput({tag, "_macEn"},    32'(macEn),    32'd0);
        checkOutput({tag, "_macA"},     32'(macA),     32'd0);
        checkOutput({tag, "_macB"},     32'(macB),     32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[5];
        logic [15:0] pool[6];
        int          cyc, clrSnap, enSnap, base, len, r;
        bit          ok;

        // Expected values are exact dot products in DLFloat16 (1.0=3E00, 2.0=4000, 3.0=4100, 5.0=4280).
        vecs[0] = '{0, 16'h3E00, 16'h4000, 16'h3E00, 16'h3E00, 2, 0, 16'h4100, 1'b0};
        vecs[1] = '{1, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 1, 0, 16'h4200, 1'b0};
        vecs[2] = '{1, 16'h4100, 16'h4000, 16'h3E00, 16'hBE00, 2, 3, 16'h4280, 1'b0};
        vecs[3] = '{0, 16'hFFFF, 16'h3E00, 16'h4000, 16'h4000, 2, 0, 16'hFFFF, 1'b0};
        vecs[4] = '{0, 16'h3C00, 16'h4000, 16'h0000, 16'h0000, 1, 0, 16'h3E00, 1'b0};
        pool = '{16'h3E00, 16'h4000, 16'h4100, 16'h3C00, 16'hBE00, 16'h0000};
        clearModel();

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            clrSnap = clrCount; enSnap = enCount;
            applyStimulus(vecs[i].id, vecs[i].a0, vecs[i].b0, vecs[i].nBeats == 1, 0);
            if (vecs[i].nBeats == 2)
                applyStimulus(vecs[i].id, vecs[i].a1, vecs[i].b1, 1'b1, vecs[i].bubble);
            waitResult(80, cyc, ok);
            checkOutput("vecDone", 32'(ok), 32'd1);
            checkOutput("vecLatency", 32'(cyc), 32'(vecs[i].nBeats + vecs[i].bubble + MacLat + 4));
            checkOutput("vecId", 32'(resId), 32'(vecs[i].id));
            checkOutput("vecData", 32'(resData), 32'(vecs[i].expData));
            checkOutput("vecOvf", 32'(resOvf), 32'(vecs[i].expOvf));
            checkOutput("vecClrCount", 32'(clrCount - clrSnap), 32'd1);
            checkOutput("vecEnCount", 32'(enCount - enSnap), 32'(vecs[i].nBeats));
            @(posedge clk);
        end

        // Fairness from reset: both requesters continuously valid with single-beat jobs.
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); #1;
        base = resLog.size();
        for (int j = 0; j < 3; j++) begin
            applyStimulus(0, DLF_TWO, DLF_TWO, 1'b1, 0);
            applyStimulus(1, DLF_TWO, DLF_TWO, 1'b1, 0);
        end
        waitLogCount(base + 6, 200, ok);
        checkOutput("fairDone", 32'(ok), 32'd1);
        if (ok) begin
            for (int j = 0; j < 6; j++) begin
                checkOutput("fairId", 32'(resLog[base + j].id), 32'(j % 2));
                checkOutput("fairData", 32'(resLog[base + j].data), 32'h4200);
            end
        end
        waitAllDone(100, ok);

        // Forced termination at MaxLen, then the leftover beat forms its own job.
        @(negedge clk); #1;
        base = resLog.size();
        for (int j = 0; j < 5; j++) applyStimulus(0, DLF_ONE, DLF_ONE, j == 4, 0);
        waitLogCount(base + 2, 200, ok);
        checkOutput("maxLenDone", 32'(ok), 32'd1);
        if (ok) begin
            checkOutput("maxLenData0", 32'(resLog[base].data), 32'h4200);
            checkOutput("maxLenOvf0", 32'(resLog[base].ovf), 32'd1);
            checkOutput("maxLenData1", 32'(resLog[base + 1].data), 32'h3E00);
            checkOutput("maxLenOvf1", 32'(resLog[base + 1].ovf), 32'd0);
        end
        waitAllDone(100, ok);

        // Result back-pressure: outputs hold, nobody is granted, no new clear.
        @(negedge clk); #1;
        readyMode = 0;
        applyStimulus(1, DLF_TWO, DLF_ONE, 1'b1, 0);
        applyStimulus(0, DLF_ONE, DLF_ONE, 1'b1, 0);
        waitResult(80, cyc, ok);
        checkOutput("stallReached", 32'(ok), 32'd1);
        clrSnap = clrCount;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); @(negedge clk);
            checkOutput("stallValid", 32'(resValid), 32'd1);
            checkOutput("stallData", 32'(resData), 32'h4000);
            checkOutput("stallId", 32'(resId), 32'd1);
            checkOutput("stallReady", 32'(reqReady), 32'd0);
        end
        checkOutput("stallNoClr", 32'(clrCount - clrSnap), 32'd0);
        readyMode = 1;
        waitAllDone(100, ok);
        checkOutput("stallDrained", 32'(ok), 32'd1);

        // Reset in the middle of a job: the partial job vanishes without a result.
        @(negedge clk); #1;
        enSnap = enCount;
        for (int j = 0; j < 4; j++) applyStimulus(0, DLF_ONE, DLF_TWO, j == 3, 0);
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (enCount >= enSnap + 2) break;
        end
        checkOutput("rstFeedReached", 32'(enCount >= enSnap + 2), 32'd1);
        rst = 1'b1; holdDrive = 1'b1;
        @(posedge clk); @(negedge clk);
        checkResetOutputs("midReset");
        clearModel();
        @(posedge clk); #1;
        rst = 1'b0; holdDrive = 1'b0;
        @(negedge clk); #1;
        base = resLog.size();
        applyStimulus(0, DLF_TWO, DLF_ONE, 1'b0, 0);
        applyStimulus(0, DLF_ONE, DLF_ONE, 1'b1, 0);
        waitLogCount(base + 1, 80, ok);
        checkOutput("postResetDone", 32'(ok), 32'd1);
        if (ok) begin
            checkOutput("postResetData", 32'(resLog[base].data), 32'h4100);
            checkOutput("postResetId", 32'(resLog[base].id), 32'd0);
        end
        repeat (10) @(posedge clk);
        checkOutput("postResetCount", 32'(resLog.size() - base), 32'd1);

        // Randomized traffic with bubbles, forced terminations and random result back-pressure.
        @(negedge clk); #1;
        readyMode = 2;
        for (int j = 0; j < 30; j++) begin
            r   = $urandom_range(0, 1);
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++)
                applyStimulus(r, pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)], k == len - 1,
                              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
        end
        waitAllDone(8000, ok);
        readyMode = 1;
        checkOutput("randomDrained", 32'(ok), 32'd1);
        checkOutput("randomPending0", 32'(expQ[0].size()), 32'd0);
        checkOutput("randomPending1", 32'(expQ[1].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
